// File: rtl/seven_segment_scanner_pkg.sv
// Shared constants for the seven-segment display path (decoders and scanner).
// A segment pattern is active-low, so the all-ones value shows nothing.
package seven_seg_pkg;

    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam int NUM_DIGITS_DEF = 4;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_e;

endpackage

// File: rtl/seven_segment_scanner_scan_timer.sv
// Slot/digit sequencer for the display scanner: slot counter, digit index,
// blank/show phase, capture strobe at the start of SHOW, and a registered frame pulse.
module scan_timer
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             enable_i,
    output logic [IDX_W-1:0] digit_idx,
    output phase_e           phase,
    output logic             capture,
    output logic             frame
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] slot_cnt_r;
    logic [CNT_W-1:0] slot_cnt_nxt_s;
    logic [IDX_W-1:0] digit_idx_r;
    logic [IDX_W-1:0] digit_idx_nxt_s;
    logic             frame_r;
    logic             frame_nxt_s;

    // Next slot/digit; a disabled scanner parks at digit 0, slot 0, which also wins over a wrap.
    always_comb begin
        slot_cnt_nxt_s  = slot_cnt_r;
        digit_idx_nxt_s = digit_idx_r;
        frame_nxt_s     = 1'b0;
        if (!enable_i) begin
            slot_cnt_nxt_s  = '0;
            digit_idx_nxt_s = '0;
        end else if (slot_cnt_r == SLOT_LAST) begin
            slot_cnt_nxt_s = '0;
            if (digit_idx_r == IDX_LAST) begin
                digit_idx_nxt_s = '0;
                frame_nxt_s     = 1'b1;
            end else begin
                digit_idx_nxt_s = digit_idx_r + IDX_W'(1);
            end
        end else begin
            slot_cnt_nxt_s = slot_cnt_r + CNT_W'(1);
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            slot_cnt_r  <= '0;
            digit_idx_r <= '0;
            frame_r     <= 1'b0;
        end else begin
            slot_cnt_r  <= slot_cnt_nxt_s;
            digit_idx_r <= digit_idx_nxt_s;
            frame_r     <= frame_nxt_s;
        end
    end

    assign digit_idx = digit_idx_r;
    assign phase     = (slot_cnt_r < BLANK_END) ? PH_BLANK : PH_SHOW;
    assign capture   = enable_i && (slot_cnt_r == BLANK_END);
    assign frame     = frame_r;

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed multi-digit seven-segment driver with per-slot dead time,
// tear-free segment capture and 16-level PWM brightness on the anodes.
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                        clk_i,
    input  logic                        resetn_i,
    input  logic                        enable_i,
    input  logic [SEG_W*NUM_DIGITS-1:0] seg_i,
    input  logic [NUM_DIGITS-1:0]       dp_i,
    input  logic [3:0]                  bright_i,
    output logic [SEG_W-1:0]            seg_o,
    output logic                        dp_o,
    output logic [NUM_DIGITS-1:0]       an_o,
    output logic [IDX_W-1:0]            digit_idx_o,
    output logic                        frame_o
);

    logic [IDX_W-1:0]      digit_idx_s;
    phase_e                phase_s;
    logic                  capture_s;
    logic                  frame_s;
    logic [3:0]            pwm_cnt_r;
    logic [SEG_W-1:0]      hold_seg_r;
    logic                  hold_dp_r;
    logic [SEG_W-1:0]      cur_seg_s;
    logic                  cur_dp_s;
    logic [SEG_W-1:0]      seg_nxt_s;
    logic                  dp_nxt_s;
    logic [NUM_DIGITS-1:0] an_nxt_s;
    logic [IDX_W-1:0]      idx_nxt_s;
    logic                  frame_nxt_s;

    scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .IDX_W       (IDX_W)
    ) u_scan_timer (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .enable_i (enable_i),
        .digit_idx(digit_idx_s),
        .phase    (phase_s),
        .capture  (capture_s),
        .frame    (frame_s)
    );

    assign cur_seg_s = seg_i[int'(digit_idx_s)*SEG_W +: SEG_W];
    assign cur_dp_s  = dp_i[digit_idx_s];

    // Free-running brightness counter, deliberately unaware of slot boundaries.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            pwm_cnt_r <= 4'd0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + 4'd1;
        end
    end

    // Hold register latched once per slot so later seg_i changes cannot tear the digit.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            hold_seg_r <= SEG_BLANK;
            hold_dp_r  <= 1'b0;
        end else if (capture_s) begin
            hold_seg_r <= cur_seg_s;
            hold_dp_r  <= cur_dp_s;
        end else begin
            hold_seg_r <= hold_seg_r;
            hold_dp_r  <= hold_dp_r;
        end
    end

    // Pin values; on the capture cycle the live slice is forwarded so segments and anode arrive together.
    always_comb begin
        seg_nxt_s   = SEG_BLANK;
        dp_nxt_s    = 1'b1;
        an_nxt_s    = {NUM_DIGITS{1'b1}};
        idx_nxt_s   = '0;
        frame_nxt_s = 1'b0;
        if (enable_i) begin
            idx_nxt_s   = digit_idx_s;
            frame_nxt_s = frame_s;
            if (phase_s == PH_SHOW) begin
                seg_nxt_s = capture_s ? cur_seg_s : hold_seg_r;
                dp_nxt_s  = ~(capture_s ? cur_dp_s : hold_dp_r);
                if (pwm_cnt_r <= bright_i) begin
                    an_nxt_s[digit_idx_s] = 1'b0;
                end else begin
                    an_nxt_s = {NUM_DIGITS{1'b1}};
                end
            end else begin
                seg_nxt_s = SEG_BLANK;
                dp_nxt_s  = 1'b1;
            end
        end else begin
            idx_nxt_s   = '0;
            frame_nxt_s = 1'b0;
        end
    end

    // Output pin registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            seg_o       <= SEG_BLANK;
            dp_o        <= 1'b1;
            an_o        <= {NUM_DIGITS{1'b1}};
            digit_idx_o <= '0;
            frame_o     <= 1'b0;
        end else begin
            seg_o       <= seg_nxt_s;
            dp_o        <= dp_nxt_s;
            an_o        <= an_nxt_s;
            digit_idx_o <= idx_nxt_s;
            frame_o     <= frame_nxt_s;
        end
    end

endmodule
